// File: rtl/fact_engine_param.sv
// Iterative factorial engine: one multiply per cycle from n down to 2, with
// sticky overflow detection and a build-time choice of wrap or saturate.
module fact_engine_param #(
  parameter int N_WIDTH      = 5,
  parameter int RESULT_WIDTH = 32,
  parameter int SATURATE     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_WIDTH-1:0]      n_in,
  output logic                    busy,
  output logic                    done,
  output logic [RESULT_WIDTH-1:0] result,
  output logic                    ovf
);

  localparam int WW = RESULT_WIDTH + N_WIDTH;
  localparam bit SAT = (SATURATE != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [N_WIDTH-1:0]      CNT_ONE  = N_WIDTH'(1);
  localparam logic [RESULT_WIDTH-1:0] PROD_ONE = RESULT_WIDTH'(1);
  localparam logic [RESULT_WIDTH-1:0] ALL_ONES = '1;

  logic [1:0]              state;
  logic [N_WIDTH-1:0]      cnt;
  logic [RESULT_WIDTH-1:0] prod;
  logic [WW-1:0]           wide;
  logic                    step_ovf;

  // Full-width product so the operand never truncates and the carry-out
  // bits expose overflow of this step.
  assign wide     = {{N_WIDTH{1'b0}}, prod} * {{RESULT_WIDTH{1'b0}}, cnt};
  assign step_ovf = |wide[WW-1:RESULT_WIDTH];

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      prod   <= PROD_ONE;
      ovf    <= 1'b0;
      result <= PROD_ONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt   <= n_in;
            prod  <= PROD_ONE;
            ovf   <= 1'b0;
            state <= S_MULT;
          end
        end
        S_MULT: begin
          if (cnt <= CNT_ONE) begin
            result <= prod;
            state  <= S_DONE;
          end else begin
            cnt <= cnt - CNT_ONE;
            if (step_ovf) ovf <= 1'b1;
            // Saturation ends the run on the first overflowing step.
            if (SAT && step_ovf) begin
              prod   <= ALL_ONES;
              result <= ALL_ONES;
              state  <= S_DONE;
            end else begin
              prod <= wide[RESULT_WIDTH-1:0];
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
